// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_pkg
// Brief    : Shared types and state encodings for the unified memory arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    localparam int XLEN = 32;

    // Arbiter FSM encoding, kept as plain constants for legacy tool flows
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;

    typedef logic [1:0] arb_state_t;

    typedef struct packed {
        logic [XLEN-1:0]     addr;
        logic [XLEN/8-1:0]   rmask;
        logic [XLEN/8-1:0]   wmask;
        logic [XLEN-1:0]     wdata;
    } mem_req_t;

endpackage
`default_nettype wire

// File: rtl/arb_req_slot.sv
`default_nettype none
// ============================================================================
// Module   : arb_req_slot
// Brief    : Single-entry request holding register with load/clear/valid.
// Revision : 1.0 - initial release
// ============================================================================
module arb_req_slot #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  clear,
    input  logic [DATA_W-1:0]     in_addr,
    input  logic [DATA_W/8-1:0]   in_rmask,
    input  logic [DATA_W/8-1:0]   in_wmask,
    input  logic [DATA_W-1:0]     in_wdata,
    output logic                  valid,
    output logic [DATA_W-1:0]     addr,
    output logic [DATA_W/8-1:0]   rmask,
    output logic [DATA_W/8-1:0]   wmask,
    output logic [DATA_W-1:0]     wdata
);

    logic                  r_valid;
    logic [DATA_W-1:0]     r_addr;
    logic [DATA_W/8-1:0]   r_rmask;
    logic [DATA_W/8-1:0]   r_wmask;
    logic [DATA_W-1:0]     r_wdata;

    // Load beats clear so a new request landing on the completion edge is kept
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_rmask <= '0;
            r_wmask <= '0;
            r_wdata <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_addr  <= in_addr;
            r_rmask <= in_rmask;
            r_wmask <= in_wmask;
            r_wdata <= in_wdata;
        end else if (clear) begin
            r_valid <= 1'b0;
        end
    end

    assign valid = r_valid;
    assign addr  = r_addr;
    assign rmask = r_rmask;
    assign wmask = r_wmask;
    assign wdata = r_wdata;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares one memory port between fetch (imem) and load/store (dmem).
//            MEM_ARB_FAIR_EN selects round-robin instead of dmem-first priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     imem_addr,
    input  logic [DATA_W/8-1:0]   imem_rmask,
    output logic [DATA_W-1:0]     imem_rdata,
    output logic                  imem_resp,
    input  logic [DATA_W-1:0]     dmem_addr,
    input  logic [DATA_W/8-1:0]   dmem_rmask,
    input  logic [DATA_W/8-1:0]   dmem_wmask,
    input  logic [DATA_W-1:0]     dmem_wdata,
    output logic [DATA_W-1:0]     dmem_rdata,
    output logic                  dmem_resp,
    output logic [DATA_W-1:0]     mem_addr,
    output logic [DATA_W/8-1:0]   mem_rmask,
    output logic [DATA_W/8-1:0]   mem_wmask,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic                  mem_resp
);

    localparam int MASK_W = DATA_W / 8;

    arb_state_t            r_state;

    logic                  w_imem_req;
    logic                  w_dmem_req;
    logic                  w_i_done;
    logic                  w_d_done;
    logic                  w_i_load;
    logic                  w_d_load;
    logic                  w_issue;
    logic                  w_pick_d;
    logic                  w_issue_i;
    logic                  w_issue_d;

    logic                  w_i_valid;
    logic [DATA_W-1:0]     w_i_addr;
    logic [MASK_W-1:0]     w_i_rmask;
    logic [MASK_W-1:0]     w_i_wmask;
    logic [DATA_W-1:0]     w_i_wdata;

    logic                  w_d_valid;
    logic [DATA_W-1:0]     w_d_addr;
    logic [MASK_W-1:0]     w_d_rmask;
    logic [MASK_W-1:0]     w_d_wmask;
    logic [DATA_W-1:0]     w_d_wdata;

    assign w_imem_req = |imem_rmask;
    assign w_dmem_req = (|dmem_rmask) | (|dmem_wmask);

    assign w_i_done = (r_state == BUSY_I) && mem_resp;
    assign w_d_done = (r_state == BUSY_D) && mem_resp;

    // A pulse into an occupied, non-completing slot is dropped
    assign w_i_load = w_imem_req && (!w_i_valid || w_i_done);
    assign w_d_load = w_dmem_req && (!w_d_valid || w_d_done);

    arb_req_slot #(.DATA_W(DATA_W)) u_imem_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (w_i_load),
        .clear    (w_i_done),
        .in_addr  (imem_addr),
        .in_rmask (imem_rmask),
        .in_wmask ({MASK_W{1'b0}}),
        .in_wdata ({DATA_W{1'b0}}),
        .valid    (w_i_valid),
        .addr     (w_i_addr),
        .rmask    (w_i_rmask),
        .wmask    (w_i_wmask),
        .wdata    (w_i_wdata)
    );

    arb_req_slot #(.DATA_W(DATA_W)) u_dmem_slot (
        .clk      (clk),
        .rst      (rst),
        .load     (w_d_load),
        .clear    (w_d_done),
        .in_addr  (dmem_addr),
        .in_rmask (dmem_rmask),
        .in_wmask (dmem_wmask),
        .in_wdata (dmem_wdata),
        .valid    (w_d_valid),
        .addr     (w_d_addr),
        .rmask    (w_d_rmask),
        .wmask    (w_d_wmask),
        .wdata    (w_d_wdata)
    );

`ifdef MEM_ARB_FAIR_EN
    logic r_last_grant_d;

    // On contention the requester that was not served last wins
    assign w_pick_d = w_d_valid && (!w_i_valid || !r_last_grant_d);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant_d <= 1'b0;
        end else if (w_issue) begin
            r_last_grant_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = w_d_valid;
`endif

    assign w_issue   = !rst && (r_state == IDLE) && (w_i_valid || w_d_valid);
    assign w_issue_d = w_issue && w_pick_d;
    assign w_issue_i = w_issue && !w_pick_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_issue_d) begin
                        r_state <= BUSY_D;
                    end else if (w_issue_i) begin
                        r_state <= BUSY_I;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_resp) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_rmask = '0;
        mem_wmask = '0;
        mem_wdata = '0;
        if (w_issue_d) begin
            mem_addr  = w_d_addr;
            mem_rmask = w_d_rmask;
            mem_wmask = w_d_wmask;
            mem_wdata = w_d_wdata;
        end else if (w_issue_i) begin
            mem_addr  = w_i_addr;
            mem_rmask = w_i_rmask;
            mem_wmask = w_i_wmask;
            mem_wdata = w_i_wdata;
        end
    end

    assign imem_resp  = w_i_done && !rst;
    assign dmem_resp  = w_d_done && !rst;
    assign imem_rdata = imem_resp ? mem_rdata : '0;
    assign dmem_rdata = dmem_resp ? mem_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Randomized self-checking bench for mem_arbiter against a
//            transaction-level model of the requesters and memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int DATA_W = 32;
`ifdef MEM_ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr = '0;
    logic [3:0]  imem_rmask = '0;
    logic [31:0] imem_rdata;
    logic        imem_resp;
    logic [31:0] dmem_addr = '0;
    logic [3:0]  dmem_rmask = '0;
    logic [3:0]  dmem_wmask = '0;
    logic [31:0] dmem_wdata = '0;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_resp = 1'b0;

    mem_arbiter #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_rmask (imem_rmask),
        .imem_rdata (imem_rdata),
        .imem_resp  (imem_resp),
        .dmem_addr  (dmem_addr),
        .dmem_rmask (dmem_rmask),
        .dmem_wmask (dmem_wmask),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_resp  (dmem_resp),
        .mem_addr   (mem_addr),
        .mem_rmask  (mem_rmask),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_resp   (mem_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model: what each requester has waiting, and which one owns the memory
    bit          pend_i, pend_d;
    logic [31:0] q_i_addr, q_d_addr, q_d_wdata;
    logic [3:0]  q_i_rm, q_d_rm, q_d_wm;
    int          owner;       // 0 none, 1 imem, 2 dmem
    int          cd;          // cycles left before memory answers
    logic [31:0] own_addr;
    bit          last_d;
    int          next_delay;
    logic [31:0] mem_img [logic [31:0]];

    int cyc = 0;
    int obs_iresp = 0, obs_dresp = 0;
    int last_icyc = 0, last_dcyc = 0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return a ^ 32'hA5A5_5A5A;
    endfunction

    task automatic cycle(input bit r, input bit ip, input logic [31:0] ia,
                         input bit dp, input logic [31:0] da, input logic [3:0] drm,
                         input logic [3:0] dwm, input logic [31:0] dwd, input bit stray);
        bit          resp_now, e_iresp, e_dresp, di, dd;
        int          who, dly;
        logic [31:0] rd, e_addr, e_wdata, old;
        logic [3:0]  e_rm, e_wm;

        rst        = r;
        imem_addr  = ia;
        imem_rmask = ip ? 4'hF : 4'h0;
        dmem_addr  = da;
        dmem_rmask = dp ? drm : 4'h0;
        dmem_wmask = dp ? dwm : 4'h0;
        dmem_wdata = dwd;

        resp_now  = (owner != 0 && cd == 0) || stray;
        rd        = (owner != 0 && cd == 0) ? mem_read(own_addr) : $urandom;
        mem_resp  = resp_now;
        mem_rdata = rd;

        who = 0;
        if (!r && owner == 0 && (pend_i || pend_d)) begin
            if (pend_i && pend_d) who = (FAIR && last_d) ? 1 : 2;
            else                  who = pend_d ? 2 : 1;
        end
        e_addr = '0; e_wdata = '0; e_rm = '0; e_wm = '0;
        if (who == 1) begin
            e_addr = q_i_addr; e_rm = q_i_rm;
        end else if (who == 2) begin
            e_addr = q_d_addr; e_rm = q_d_rm; e_wm = q_d_wm; e_wdata = q_d_wdata;
        end
        e_iresp = !r && resp_now && owner == 1;
        e_dresp = !r && resp_now && owner == 2;

        #3;
        check_eq("mem_addr",  mem_addr,  e_addr);
        check_eq("mem_rmask", {28'h0, mem_rmask}, {28'h0, e_rm});
        check_eq("mem_wmask", {28'h0, mem_wmask}, {28'h0, e_wm});
        check_eq("mem_wdata", mem_wdata, e_wdata);
        check_eq("imem_resp", {31'h0, imem_resp}, {31'h0, e_iresp});
        check_eq("dmem_resp", {31'h0, dmem_resp}, {31'h0, e_dresp});
        if (e_iresp) check_eq("imem_rdata", imem_rdata, rd);
        if (e_dresp && q_d_wm == 4'h0) check_eq("dmem_rdata", dmem_rdata, rd);
        if (r) begin
            check_eq("rst_imem_rdata", imem_rdata, 32'h0);
            check_eq("rst_dmem_rdata", dmem_rdata, 32'h0);
        end
        if (imem_resp) begin obs_iresp++; last_icyc = cyc; end
        if (dmem_resp) begin obs_dresp++; last_dcyc = cyc; end

        if (r) begin
            pend_i = 0; pend_d = 0; owner = 0; last_d = 0;
        end else begin
            di = resp_now && owner == 1;
            dd = resp_now && owner == 2;
            if (who != 0) begin
                dly = (next_delay > 0) ? next_delay : int'($urandom_range(1, 4));
                next_delay = 0;
                owner  = who;
                cd     = dly - 1;
                last_d = (who == 2);
                own_addr = (who == 1) ? q_i_addr : q_d_addr;
                if (who == 2 && q_d_wm != 4'h0) begin
                    old = mem_read(q_d_addr);
                    for (int b = 0; b < 4; b++)
                        if (q_d_wm[b]) old[b*8 +: 8] = q_d_wdata[b*8 +: 8];
                    mem_img[q_d_addr] = old;
                end
            end else if (resp_now && owner != 0) begin
                owner = 0;
            end else if (owner != 0) begin
                cd--;
            end
            if (ip && (!pend_i || di)) begin
                pend_i = 1; q_i_addr = ia; q_i_rm = 4'hF;
            end else if (di) begin
                pend_i = 0;
            end
            if (dp && (!pend_d || dd)) begin
                pend_d = 1; q_d_addr = da; q_d_rm = drm; q_d_wm = dwm; q_d_wdata = dwd;
            end else if (dd) begin
                pend_d = 0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 32'h0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
    endtask

    initial begin
        int base_i, base_d, t0;
        bit sent, ip, dp, ld;
        logic [31:0] da;
        logic [3:0]  m;

        pend_i = 0; pend_d = 0; owner = 0; cd = 0; last_d = 0; next_delay = 0;
        @(posedge clk);
        #1;

        // Reset for 3 cycles, including a stray request that reset must swallow
        cycle(1, 0, 32'h0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
        cycle(1, 0, 32'h0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
        cycle(1, 1, 32'h1234, 1, 32'h5678, 4'hF, 4'h0, 32'h0, 0);
        repeat (4) idle();

        // Single fetch, memory answers 3 cycles after issue
        mem_img[32'h1ECE_B000] = 32'h0000_0013;
        base_i = obs_iresp; base_d = obs_dresp;
        next_delay = 3;
        t0 = cyc;
        cycle(0, 1, 32'h1ECE_B000, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
        for (int k = 0; k < 12 && obs_iresp == base_i; k++) idle();
        check_eq("fetch_resp_cnt", obs_iresp - base_i, 1);
        check_eq("fetch_latency", last_icyc - t0, 4);
        check_eq("fetch_no_dresp", obs_dresp - base_d, 0);

        // Simultaneous fetch and store; last grant was imem so dmem goes first
        base_i = obs_iresp; base_d = obs_dresp;
        cycle(0, 1, 32'h1ECE_B004, 1, 32'h1ECE_C000, 4'h0, 4'h3, 32'h0000_BEEF, 0);
        for (int k = 0; k < 20 && (obs_iresp == base_i || obs_dresp == base_d); k++) idle();
        check_eq("pair1_iresp_cnt", obs_iresp - base_i, 1);
        check_eq("pair1_dresp_cnt", obs_dresp - base_d, 1);
        check_eq("pair1_dmem_first", last_dcyc < last_icyc, 1);

        // Lone load makes dmem the last grant, then contend again
        base_d = obs_dresp;
        cycle(0, 0, 32'h0, 1, 32'h1ECE_C010, 4'hF, 4'h0, 32'h0, 0);
        for (int k = 0; k < 12 && obs_dresp == base_d; k++) idle();
        base_i = obs_iresp; base_d = obs_dresp;
        cycle(0, 1, 32'h1ECE_B008, 1, 32'h1ECE_C020, 4'hF, 4'h0, 32'h0, 0);
        for (int k = 0; k < 20 && (obs_iresp == base_i || obs_dresp == base_d); k++) idle();
        check_eq("pair2_both_done", (obs_iresp - base_i) + (obs_dresp - base_d), 2);
        check_eq("pair2_order_imem_first", last_icyc < last_dcyc, FAIR);

        // Reset while a load is outstanding; late mem_resp must be ignored
        next_delay = 20;
        cycle(0, 0, 32'h0, 1, 32'h1ECE_C030, 4'hF, 4'h0, 32'h0, 0);
        for (int k = 0; k < 5 && owner != 2; k++) idle();
        check_eq("busy_d_reached", owner, 2);
        base_d = obs_dresp;
        cycle(1, 0, 32'h0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
        cycle(1, 0, 32'h0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
        idle();
        cycle(0, 0, 32'h0, 0, 32'h0, 4'h0, 4'h0, 32'h0, 1);
        check_eq("abandoned_no_dresp", obs_dresp - base_d, 0);
        base_i = obs_iresp;
        cycle(0, 1, 32'h1ECE_B00C, 0, 32'h0, 4'h0, 4'h0, 32'h0, 0);
        for (int k = 0; k < 12 && obs_iresp == base_i; k++) idle();
        check_eq("post_rst_fetch", obs_iresp - base_i, 1);

        // Back-to-back loads: second pulse lands on the first's mem_resp cycle
        base_d = obs_dresp;
        sent = 0;
        cycle(0, 0, 32'h0, 1, 32'h1ECE_C040, 4'hF, 4'h0, 32'h0, 0);
        for (int k = 0; k < 12 && !sent; k++) begin
            if (owner == 2 && cd == 0) begin
                cycle(0, 0, 32'h0, 1, 32'h1ECE_C044, 4'h3, 4'h0, 32'h0, 0);
                sent = 1;
            end else begin
                idle();
            end
        end
        for (int k = 0; k < 12 && obs_dresp < base_d + 2; k++) idle();
        check_eq("b2b_sent", sent, 1);
        check_eq("b2b_dresp_cnt", obs_dresp - base_d, 2);

        // Randomized traffic, occasional illegal pulses and resets
        for (int c = 0; c < 3000; c++) begin
            ip = (!pend_i || (owner == 1 && cd == 0)) ? ($urandom_range(0, 2) == 0)
                                                      : ($urandom_range(0, 15) == 0);
            dp = (!pend_d || (owner == 2 && cd == 0)) ? ($urandom_range(0, 2) == 0)
                                                      : ($urandom_range(0, 15) == 0);
            ld = $urandom_range(0, 1) == 1;
            m  = 4'($urandom_range(1, 15));
            da = $urandom & 32'h0000_00FC;
            cycle($urandom_range(0, 499) == 0, ip, $urandom & 32'hFFFF_FFFC,
                  dp, da, ld ? m : 4'h0, ld ? 4'h0 : m, $urandom, 0);
        end
        for (int k = 0; k < 50 && (owner != 0 || pend_i || pend_d); k++) idle();
        check_eq("drained", {31'h0, (owner != 0 || pend_i || pend_d)}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
